// File: rtl/store_align_pkg.sv
// Shared definitions for the store aligner: one-hot width codes, FSM states
// and small helpers used by both the top level and the mask generator.
package store_align_pkg;

    localparam logic [3:0] Wdt8  = 4'b0001;
    localparam logic [3:0] Wdt16 = 4'b0010;
    localparam logic [3:0] Wdt32 = 4'b0100;
    localparam logic [3:0] Wdt64 = 4'b1000;
    localparam int         WdtCount = 4;
    localparam int         BeatBytes = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } alignStateT;

    // Byte count for a width code; 0 flags an illegal (non-one-hot) code.
    function automatic logic [3:0] wdtBytes(input logic [WdtCount-1:0] wdt);
        case (wdt)
            Wdt8:    return 4'd1;
            Wdt16:   return 4'd2;
            Wdt32:   return 4'd4;
            Wdt64:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic isCross(input logic [2:0] off, input logic [3:0] bytes);
        return ({1'b0, off} + bytes) > 4'(BeatBytes);
    endfunction

endpackage

// File: rtl/store_mask_gen.sv
// Combinational strobe and lane-shift generator producing both beats of a
// store that may straddle an 8-byte boundary.
module store_mask_gen
    import store_align_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]          off,
    input  logic [3:0]          bytes,
    input  logic [XLEN-1:0]     wdata,
    output logic [XLEN/8-1:0]   strb0,
    output logic [XLEN/8-1:0]   strb1,
    output logic [XLEN-1:0]     data0,
    output logic [XLEN-1:0]     data1
);

    localparam int Lanes = XLEN / 8;

    logic [2*Lanes-1:0] maskWide;
    logic [2*XLEN-1:0]  dataWide;

    // Shifting into a double-width vector yields beat0 in the low half and the
    // spill-over for beat1 in the high half.
    always_comb begin
        maskWide = (((2*Lanes)'(1) << bytes) - (2*Lanes)'(1)) << off;
        dataWide = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        strb0    = maskWide[Lanes-1:0];
        strb1    = maskWide[2*Lanes-1:Lanes];
        data0    = dataWide[XLEN-1:0];
        data1    = dataWide[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/store_align.sv
// Store aligner: turns a right-justified store into one or two lane-aligned
// memory write beats. Define STORE_MISALIGN_SPLIT_EN to split crossing stores.
module store_align
    import store_align_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [WdtCount-1:0] req_wdt,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    output logic [AW-1:0]       mem_waddr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic                done,
    output logic                err
);

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    alignStateT state, stateNext;
    logic errReg, errNext;

    logic [AW-1:0]     reqAddr_p0;
    logic [XLEN-1:0]   reqWdata_p0;
    logic [3:0]        bytes_p0;

    logic [AW-1:0]     beatAddr;
    logic [XLEN/8-1:0] strb0, strb1;
    logic [XLEN-1:0]   data0, data1;
    logic              accept;
    logic [3:0]        bytesIn;
    logic              crossIn;
    logic              cross_p0;

    assign accept   = req_valid && req_ready;
    assign bytesIn  = wdtBytes(req_wdt);
    assign crossIn  = isCross(req_addr[2:0], bytesIn);
    assign cross_p0 = isCross(reqAddr_p0[2:0], bytes_p0);
    assign beatAddr = {reqAddr_p0[AW-1:3], 3'b000};

    // Request capture: payload only, never read outside the beat states
    always_ff @(posedge clk) begin
        if (accept) begin
            reqAddr_p0  <= req_addr;
            reqWdata_p0 <= req_wdata;
            bytes_p0    <= bytesIn;
        end
    end

    store_mask_gen #(.XLEN(XLEN)) uMaskGen (
        .off   (reqAddr_p0[2:0]),
        .bytes (bytes_p0),
        .wdata (reqWdata_p0),
        .strb0 (strb0),
        .strb1 (strb1),
        .data0 (data0),
        .data1 (data1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            errReg <= 1'b0;
        end else begin
            state  <= stateNext;
            errReg <= errNext;
        end
    end

    // Outputs decode straight from state so reset clears them immediately
    always_comb begin
        stateNext  = state;
        errNext    = errReg;
        req_ready  = 1'b0;
        mem_wvalid = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!$onehot(req_wdt) || (crossIn && !SplitEn)) begin
                        errNext   = 1'b1;
                        stateNext = RESP;
                    end else begin
                        errNext   = 1'b0;
                        stateNext = BEAT0;
                    end
                end
            end
            BEAT0: begin
                mem_wvalid = 1'b1;
                mem_waddr  = beatAddr;
                mem_wdata  = data0;
                mem_wstrb  = strb0;
                if (mem_wready) stateNext = (cross_p0 && SplitEn) ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_wvalid = 1'b1;
                mem_waddr  = beatAddr + AW'(BeatBytes);
                mem_wdata  = data1;
                mem_wstrb  = strb1;
                if (mem_wready) stateNext = RESP;
            end
            RESP: begin
                done      = 1'b1;
                err       = errReg;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_align.sv
// Self-checking bench for store_align: directed vectors plus randomized stores
// checked against a byte-level reference model.
module tb_store_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid;
    logic        reqReady;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;
    logic [3:0]  reqWdt;
    logic        memWvalid;
    logic        memWready;
    logic [63:0] memWaddr;
    logic [63:0] memWdata;
    logic [7:0]  memWstrb;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    store_align #(.XLEN(64), .AW(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_addr   (reqAddr),
        .req_wdata  (reqWdata),
        .req_wdt    (reqWdt),
        .mem_wvalid (memWvalid),
        .mem_wready (memWready),
        .mem_waddr  (memWaddr),
        .mem_wdata  (memWdata),
        .mem_wstrb  (memWstrb),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Observations of the last store run
    int          obsN, obsLat, obsUnstable, obsStalled, obsReadyHigh;
    logic [63:0] obsAddr [2];
    logic [63:0] obsData [2];
    logic [7:0]  obsStrb [2];
    logic        obsErr, obsDoneAfter, obsTimeout;

    // Reference expectations
    int          expN, expLat;
    logic [63:0] expAddr [2];
    logic [63:0] expData [2];
    logic [7:0]  expStrb [2];
    logic        expErr;

    // Memory view: which bytes land where, from the store's own byte range.
    task automatic model(input logic [63:0] a, input logic [63:0] d, input logic [3:0] w, input int stall);
        int nbytes;
        int off;
        logic [127:0] wide;
        logic [15:0]  lanes;
        nbytes = (w == 4'b0001) ? 1 : (w == 4'b0010) ? 2 : (w == 4'b0100) ? 4 : (w == 4'b1000) ? 8 : 0;
        off    = int'(a % 8);
        expN = 0; expErr = 1'b0;
        expAddr[0] = '0; expAddr[1] = '0; expData[0] = '0; expData[1] = '0;
        expStrb[0] = '0; expStrb[1] = '0;
        if (nbytes == 0 || (off + nbytes > 8 && !SplitEn)) begin
            expErr = 1'b1;
            expLat = 2;
            return;
        end
        wide  = 128'(d) * (128'(1) << (8 * off));
        lanes = '0;
        for (int i = 0; i < nbytes; i++) lanes[off + i] = 1'b1;
        expN       = (off + nbytes > 8) ? 2 : 1;
        expAddr[0] = a - 64'(off);
        expAddr[1] = a - 64'(off) + 64'd8;
        expData[0] = wide[63:0];
        expData[1] = wide[127:64];
        expStrb[0] = lanes[7:0];
        expStrb[1] = lanes[15:8];
        expLat     = 2 + expN + stall;
    endtask

    // Drives one request and records every beat; the accept cycle is cycle 1.
    task automatic run_store(input logic [63:0] a, input logic [63:0] d, input logic [3:0] w, input int stall);
        int n;
        int stallLeft;
        logic haveSnap;
        logic [63:0] snapA, snapD;
        logic [7:0]  snapS;
        obsN = 0; obsLat = 0; obsErr = 1'b0; obsDoneAfter = 1'b0; obsTimeout = 1'b1;
        obsUnstable = 0; obsStalled = 0; obsReadyHigh = 0;
        obsAddr[0] = '0; obsAddr[1] = '0; obsData[0] = '0; obsData[1] = '0;
        obsStrb[0] = '0; obsStrb[1] = '0;
        haveSnap = 1'b0; snapA = '0; snapD = '0; snapS = '0;
        stallLeft = stall;
        @(negedge clk);
        reqAddr = a; reqWdata = d; reqWdt = w; reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        n = 1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n++;
            if (reqReady) obsReadyHigh++;
            if (done) begin
                obsLat = n; obsErr = err; obsTimeout = 1'b0;
                @(negedge clk);
                obsDoneAfter = done;
                break;
            end
            if (memWvalid) begin
                if (haveSnap && (memWaddr !== snapA || memWdata !== snapD || memWstrb !== snapS))
                    obsUnstable++;
                if (obsN == 0 && stallLeft > 0) begin
                    memWready = 1'b0;
                    haveSnap = 1'b1; snapA = memWaddr; snapD = memWdata; snapS = memWstrb;
                    stallLeft--; obsStalled++;
                end else begin
                    memWready = 1'b1;
                    haveSnap = 1'b0;
                    if (obsN < 2) begin
                        obsAddr[obsN] = memWaddr; obsData[obsN] = memWdata; obsStrb[obsN] = memWstrb;
                    end
                    obsN++;
                end
            end else begin
                memWready = 1'b1;
            end
        end
        memWready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; reqValid = 1'b0; reqAddr = '0; reqWdata = '0; reqWdt = '0; memWready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({memWvalid, memWaddr, memWdata, memWstrb, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got wvalid=%0b waddr=%h wdata=%h wstrb=%h done=%0b err=%0b, need all 0",
                     memWvalid, memWaddr, memWdata, memWstrb, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (reqReady !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b need 1", reqReady); end
    endtask

    task automatic test_sb();
        run_store(64'h8000_0003, 64'hAB, 4'b0001, 0);
        total++; if (obsTimeout) begin bad++; $display("FAIL sb_timeout: no done within bound"); end
        total++; if (obsN !== 1) begin bad++; $display("FAIL sb_beats: got %0d need 1", obsN); end
        total++; if (obsAddr[0] !== 64'h8000_0000) begin bad++; $display("FAIL sb_waddr: got %h need 0000000080000000", obsAddr[0]); end
        total++; if (obsStrb[0] !== 8'h08) begin bad++; $display("FAIL sb_wstrb: got %h need 08", obsStrb[0]); end
        total++; if (obsData[0] !== 64'h0000_0000_AB00_0000) begin bad++; $display("FAIL sb_wdata: got %h need 00000000ab000000", obsData[0]); end
        total++; if (obsErr !== 1'b0) begin bad++; $display("FAIL sb_err: got %0b need 0", obsErr); end
        total++; if (obsDoneAfter !== 1'b0) begin bad++; $display("FAIL sb_done_pulse: done still %0b next cycle, need 0", obsDoneAfter); end
    endtask

    task automatic test_sd();
        run_store(64'h10, 64'h1122_3344_5566_7788, 4'b1000, 0);
        total++; if (obsN !== 1) begin bad++; $display("FAIL sd_beats: got %0d need 1", obsN); end
        total++; if (obsAddr[0] !== 64'h10) begin bad++; $display("FAIL sd_waddr: got %h need 10", obsAddr[0]); end
        total++; if (obsStrb[0] !== 8'hFF) begin bad++; $display("FAIL sd_wstrb: got %h need ff", obsStrb[0]); end
        total++; if (obsData[0] !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL sd_wdata: got %h need 1122334455667788", obsData[0]); end
        total++; if (obsLat !== 3) begin bad++; $display("FAIL sd_latency: got %0d need 3", obsLat); end
    endtask

    task automatic test_sw_cross();
        run_store(64'h6, 64'hDEAD_BEEF, 4'b0100, 0);
        if (SplitEn) begin
            total++; if (obsN !== 2) begin bad++; $display("FAIL sw_beats: got %0d need 2", obsN); end
            total++; if (obsAddr[0] !== 64'h0 || obsStrb[0] !== 8'hC0 || obsData[0] !== 64'hBEEF_0000_0000_0000) begin
                bad++; $display("FAIL sw_beat0: got a=%h s=%h d=%h need a=0 s=c0 d=beef000000000000", obsAddr[0], obsStrb[0], obsData[0]);
            end
            total++; if (obsAddr[1] !== 64'h8 || obsStrb[1] !== 8'h03 || obsData[1] !== 64'hDEAD) begin
                bad++; $display("FAIL sw_beat1: got a=%h s=%h d=%h need a=8 s=03 d=dead", obsAddr[1], obsStrb[1], obsData[1]);
            end
            total++; if (obsLat !== 4 || obsErr !== 1'b0) begin bad++; $display("FAIL sw_done: got lat=%0d err=%0b need lat=4 err=0", obsLat, obsErr); end
        end else begin
            total++; if (obsN !== 0) begin bad++; $display("FAIL sw_nobeat: got %0d beats need 0", obsN); end
            total++; if (obsErr !== 1'b1 || obsTimeout) begin bad++; $display("FAIL sw_err: got err=%0b timeout=%0b need err=1", obsErr, obsTimeout); end
        end
    endtask

    task automatic test_bad_wdt();
        run_store(64'h20, 64'h55, 4'b0011, 0);
        total++; if (obsN !== 0) begin bad++; $display("FAIL badwdt_nobeat: got %0d beats need 0", obsN); end
        total++; if (obsErr !== 1'b1 || obsTimeout) begin bad++; $display("FAIL badwdt_err: got err=%0b timeout=%0b need err=1", obsErr, obsTimeout); end
        total++; if (obsLat !== 2) begin bad++; $display("FAIL badwdt_latency: got %0d need 2", obsLat); end
    endtask

    task automatic test_stall();
        run_store(64'h48, 64'h0123_4567_89AB_CDEF, 4'b1000, 5);
        total++; if (obsStalled !== 5) begin bad++; $display("FAIL stall_cycles: got %0d need 5", obsStalled); end
        total++; if (obsUnstable !== 0) begin bad++; $display("FAIL stall_stable: got %0d changes need 0", obsUnstable); end
        total++; if (obsReadyHigh !== 0) begin bad++; $display("FAIL stall_ready: req_ready high %0d cycles need 0", obsReadyHigh); end
        total++; if (obsData[0] !== 64'h0123_4567_89AB_CDEF || obsAddr[0] !== 64'h48) begin
            bad++; $display("FAIL stall_payload: got a=%h d=%h need a=48 d=0123456789abcdef", obsAddr[0], obsData[0]);
        end
        total++; if (obsLat !== 8) begin bad++; $display("FAIL stall_latency: got %0d need 8", obsLat); end
    endtask

    task automatic test_reset_mid();
        int vldAfter;
        @(negedge clk);
        if (SplitEn) begin
            reqAddr = 64'h6; reqWdata = 64'hDEAD_BEEF; reqWdt = 4'b0100;
        end else begin
            reqAddr = 64'h10; reqWdata = 64'h1122_3344_5566_7788; reqWdt = 4'b1000;
        end
        reqValid = 1'b1;
        @(posedge clk);
        #1 reqValid = 1'b0;
        memWready = SplitEn;
        @(posedge clk);
        #1 memWready = 1'b0;
        total++;
        if (memWvalid !== 1'b1) begin bad++; $display("FAIL midrst_inbeat: wvalid %0b before reset need 1", memWvalid); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({memWvalid, memWaddr, memWdata, memWstrb, done, err} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got wvalid=%0b waddr=%h wdata=%h wstrb=%h done=%0b err=%0b, need all 0",
                     memWvalid, memWaddr, memWdata, memWstrb, done, err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; memWready = 1'b1;
        vldAfter = 0;
        repeat (3) begin
            @(negedge clk);
            if (memWvalid || done) vldAfter++;
        end
        total++;
        if (vldAfter !== 0 || reqReady !== 1'b1) begin
            bad++; $display("FAIL midrst_abandon: got activity=%0d ready=%0b need 0 and 1", vldAfter, reqReady);
        end
        run_store(64'h8000_0003, 64'hAB, 4'b0001, 0);
        total++;
        if (obsN !== 1 || obsStrb[0] !== 8'h08 || obsData[0] !== 64'hAB00_0000 || obsErr !== 1'b0 || obsLat !== 3) begin
            bad++; $display("FAIL midrst_fresh_sb: got n=%0d s=%h d=%h err=%0b lat=%0d need n=1 s=08 d=ab000000 err=0 lat=3",
                            obsN, obsStrb[0], obsData[0], obsErr, obsLat);
        end
    endtask

    task automatic test_random();
        logic [63:0] a, d;
        logic [3:0]  w;
        int          r, stall;
        for (int k = 0; k < 40; k++) begin
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            r = int'($urandom_range(0, 9));
            w = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom_range(0, 15));
            stall = int'($urandom_range(0, 2));
            model(a, d, w, stall);
            run_store(a, d, w, stall);
            total++;
            if (obsErr !== expErr || obsN !== expN || obsLat !== expLat || obsDoneAfter !== 1'b0 || obsTimeout) begin
                bad++; $display("FAIL rand%0d_ctrl: got err=%0b n=%0d lat=%0d to=%0b need err=%0b n=%0d lat=%0d (a=%h w=%b)",
                                k, obsErr, obsN, obsLat, obsTimeout, expErr, expN, expLat, a, w);
            end
            for (int b = 0; b < expN; b++) begin
                total++;
                if (obsAddr[b] !== expAddr[b] || obsData[b] !== expData[b] || obsStrb[b] !== expStrb[b]) begin
                    bad++; $display("FAIL rand%0d_beat%0d: got a=%h d=%h s=%h need a=%h d=%h s=%h",
                                    k, b, obsAddr[b], obsData[b], obsStrb[b], expAddr[b], expData[b], expStrb[b]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sd();
        test_sw_cross();
        test_bad_wdt();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_align.md
STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 SHALL have parameter XLEN, default 64, store data width and memory beat width in bits.
REQ-002 SHALL have parameter AW, default 64, address width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, store request present.
REQ-006 SHALL have port req_ready, output, 1, store request accepted when high together with req_valid.
REQ-007 SHALL have port req_addr, input, AW, byte address of the store.
REQ-008 SHALL have port req_wdata, input, XLEN, store data, right-justified.
REQ-009 SHALL have port req_wdt, input, 4, one-hot width: bit0 = 8, bit1 = 16, bit2 = 32, bit3 = 64 bits.
REQ-010 SHALL have port mem_wvalid, output, 1, write beat valid.
REQ-011 SHALL have port mem_wready, input, 1, memory accepts the beat.
REQ-012 SHALL have port mem_waddr, output, AW, 8-byte-aligned beat address.
REQ-013 SHALL have port mem_wdata, output, XLEN, lane-aligned write data.
REQ-014 SHALL have port mem_wstrb, output, XLEN/8, byte enables.
REQ-015 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1, error flag, valid only while done is high.

Function
REQ-017 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-018 SHALL drive req_ready = 1 only in IDLE; the request fields are registered on the handshake.
REQ-019 SHALL compute on accept: off = addr[2:0]; bytes = 1/2/4/8; mask = (1<<bytes)-1; cross = off+bytes > 8.
REQ-020 SHALL transition IDLE to RESP with err = 1, without any memory beat, when req_wdt is not one-hot.
REQ-021 SHALL otherwise transition IDLE to BEAT0 on accept.
REQ-022 SHALL present in BEAT0: mem_waddr = addr with low 3 bits cleared; mem_wdata = wdata << 8*off, truncated to XLEN; mem_wstrb = (mask << off)[7:0].
REQ-023 SHALL present in BEAT1: mem_waddr = BEAT0 address + 8; mem_wdata = wdata >> 8*(8-off); mem_wstrb = mask >> (8-off).
REQ-024 SHALL assert mem_wvalid throughout BEAT0/BEAT1 and hold address, data and strobe stable until mem_wready is sampled high.
REQ-025 SHALL advance BEAT0 on handshake to BEAT1 if cross, else to RESP; BEAT1 on handshake to RESP.
REQ-026 SHALL assert done for exactly one cycle in RESP, then return to IDLE; err = 0 unless set by REQ-020 or REQ-031.
REQ-027 SHALL achieve a latency of 3 cycles from accept to done for a non-crossing store with mem_wready held high, and 4 cycles for a crossing store.
REQ-028 SHALL drive mem_wvalid low, and mem_wdata and mem_wstrb as 0, outside BEAT0/BEAT1.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-beat, immediately force state = IDLE, req_ready = 1 once released, and mem_wvalid, mem_wstrb, mem_wdata, mem_waddr, done and err = 0; any in-flight store is abandoned.

Configuration
REQ-030 SHALL, with STORE_MISALIGN_SPLIT_EN defined, perform crossing stores as two beats per REQ-023 and REQ-025.
REQ-031 SHALL, with STORE_MISALIGN_SPLIT_EN undefined, send a crossing store from IDLE directly to RESP with err = 1 and issue no memory beat; non-crossing misaligned stores remain legal.

Structure
REQ-032 SHALL take the one-hot width codes (Wdt8/16/32/64) and the width-count constant from the shared defines header; no new global constants.
REQ-033 SHALL place strobe and shift generation in one combinational sub-module, store_mask_gen, instantiated once.

Verification
REQ-034 SHALL cover: sb, addr 0x80000003, data 0xAB -> one beat, waddr 0x80000000, wstrb 0x08, wdata 0x00000000AB000000, done with err = 0.
REQ-035 SHALL cover: sd, addr 0x10, data 0x1122334455667788 -> waddr 0x10, wstrb 0xFF, same data, done 3 cycles after accept.
REQ-036 SHALL cover, with macro defined: sw, addr 0x6, data 0xDEADBEEF -> beat0 waddr 0x0, wstrb 0xC0, wdata 0xBEEF000000000000; beat1 waddr 0x8, wstrb 0x03, wdata 0xDEAD.
REQ-037 SHALL cover: same sw without the macro -> no mem_wvalid, done = 1 with err = 1. Also req_wdt = 0b0011 -> err = 1, no beat.
REQ-038 SHALL cover: mem_wready held low for 5 cycles in BEAT0 -> mem_wvalid and payload stable every cycle, req_ready = 0.
REQ-039 SHALL cover: rst_n asserted during BEAT1 -> all outputs 0 in the same cycle; after release, a fresh sb completes normally.
